// File: rtl/dcache_ctrl_fsm.sv
// Data-cache controller FSM: multi-beat write-back / fill over a req/ack
// memory handshake, selectable write-allocate policy, and saturating
// hit/miss performance counters.
module dcache_ctrl_fsm #(
  parameter int WORDS_PER_LINE = 4,
  parameter bit WRITE_ALLOC    = 1'b1,
  parameter int CNT_W          = 16,
  localparam int BW = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             cpu_rd,
  input  logic             cpu_wr,
  input  logic             hit,
  input  logic             dirty,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             mem_we,
  output logic             wb_sel,
  output logic [BW-1:0]    beat_idx,
  output logic             fill_we,
  output logic             fill_done,
  output logic             stall,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_WB, S_ALLOC, S_MEMWR, S_DONE
  } state_t;

  localparam logic [BW-1:0] LAST_BEAT = BW'(WORDS_PER_LINE - 1);

  state_t           r_state, w_nxt;
  logic [BW-1:0]    r_cnt, w_cnt_nxt;
  logic             r_replay;
  logic [CNT_W-1:0] r_hit_cnt, r_miss_cnt;

  logic w_req, w_last, w_idle, w_hit_inc, w_miss_inc, w_replay_nxt;
  logic w_mem_req, w_mem_we, w_wb_sel, w_fill_we, w_fill_done, w_stall;
  logic [BW-1:0] w_beat;

  // A simultaneous rd+wr is a read, so only a pure store is a "write".
  assign w_req      = cpu_rd | cpu_wr;
  assign w_last     = (r_cnt == LAST_BEAT);
  assign w_idle     = (r_state == S_IDLE);
  assign w_miss_inc = w_idle & w_req & ~hit;
  // The replay cycle after a fill re-presents the missed access; don't count it twice.
  assign w_hit_inc  = w_idle & w_req & hit & ~r_replay;
  assign w_replay_nxt = (r_state == S_ALLOC) & mem_ack & w_last;

  // Next-state, beat counter and combinational outputs.
  always_comb begin
    w_nxt       = r_state;
    w_cnt_nxt   = r_cnt;
    w_mem_req   = 1'b0;
    w_mem_we    = 1'b0;
    w_wb_sel    = 1'b0;
    w_fill_we   = 1'b0;
    w_fill_done = 1'b0;
    w_stall     = 1'b0;
    w_beat      = '0;
    case (r_state)
      S_IDLE: begin
        w_stall = w_req & ~hit;
        if (w_req && !hit) begin
          if (cpu_wr && !cpu_rd && !WRITE_ALLOC) w_nxt = S_MEMWR;
          else if (dirty)                        w_nxt = S_WB;
          else                                   w_nxt = S_ALLOC;
        end
      end
      S_WB: begin
        w_stall   = 1'b1;
        w_mem_req = 1'b1;
        w_mem_we  = 1'b1;
        w_wb_sel  = 1'b1;
        w_beat    = r_cnt;
        if (mem_ack) begin
          w_cnt_nxt = w_last ? '0 : r_cnt + 1'b1;
          if (w_last) w_nxt = S_ALLOC;
        end
      end
      S_ALLOC: begin
        w_stall   = 1'b1;
        w_mem_req = 1'b1;
        w_fill_we = mem_ack;
        w_beat    = r_cnt;
        if (mem_ack) begin
          w_cnt_nxt = w_last ? '0 : r_cnt + 1'b1;
          if (w_last) begin
            w_fill_done = 1'b1;
            w_nxt       = S_IDLE;
          end
        end
      end
      S_MEMWR: begin
        w_stall   = 1'b1;
        w_mem_req = 1'b1;
        w_mem_we  = 1'b1;
        if (mem_ack) w_nxt = S_DONE;
      end
      S_DONE:  w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  // State, beat counter and replay flag registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_replay <= 1'b0;
    end else begin
      r_state  <= w_nxt;
      r_cnt    <= w_cnt_nxt;
      r_replay <= w_replay_nxt;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      if (w_hit_inc && (r_hit_cnt != {CNT_W{1'b1}}))   r_hit_cnt  <= r_hit_cnt + 1'b1;
      if (w_miss_inc && (r_miss_cnt != {CNT_W{1'b1}})) r_miss_cnt <= r_miss_cnt + 1'b1;
    end
  end

  // Every output reads zero while reset is held, including mid-burst.
  assign mem_req   = w_mem_req   & ~RST;
  assign mem_we    = w_mem_we    & ~RST;
  assign wb_sel    = w_wb_sel    & ~RST;
  assign fill_we   = w_fill_we   & ~RST;
  assign fill_done = w_fill_done & ~RST;
  assign stall     = w_stall     & ~RST;
  assign beat_idx  = RST ? '0 : w_beat;
  assign hit_cnt   = RST ? '0 : r_hit_cnt;
  assign miss_cnt  = RST ? '0 : r_miss_cnt;

endmodule
